gray_count_rx: RTL and testbench

Receive-side endpoint of the rsync event-count crossing. It samples a Gray-coded free-running event count driven from a remote clock domain and resynchronises it into the local clock. It then converts the count to binary and accumulates the per-cycle increments into a local pending-event credit. Local logic drains that credit one event per cycle through a valid/ready pop interface.

---
 rtl/rsync_pkg.sv | 33 +++
 rtl/rsync_sync_stage.sv | 28 ++
 rtl/gray_count_rx.sv | 80 ++++++++
 tb/tb_gray_count_rx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsync_pkg.sv
// Shared definitions for the rsync event-count crossing: default sizes and
// Gray/binary conversion helpers usable at any width up to RSYNC_MAX_W.
package rsync_pkg;

    localparam int unsigned RSYNC_WIDTH       = 4;
    localparam int unsigned RSYNC_SYNC_STAGES = 2;
    localparam int unsigned RSYNC_MAX_W       = 32;

    typedef logic [RSYNC_MAX_W-1:0] rsync_word_t;

    function automatic rsync_word_t rsync_mask(input int unsigned w);
        return (w >= RSYNC_MAX_W) ? '1 : ((rsync_word_t'(1) << w) - rsync_word_t'(1));
    endfunction

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    function automatic rsync_word_t gray2bin(input rsync_word_t g, input int unsigned w);
        rsync_word_t gm;
        rsync_word_t b;
        gm = g & rsync_mask(w);
        b  = '0;
        for (int unsigned i = 0; i < RSYNC_MAX_W; i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

    function automatic rsync_word_t bin2gray(input rsync_word_t b, input int unsigned w);
        rsync_word_t bm;
        bm = b & rsync_mask(w);
        return bm ^ (bm >> 1);
    endfunction

endpackage

// File: rtl/rsync_sync_stage.sv
// N-flop bit-vector synchronizer with asynchronous active-low reset; shared
// by the rsync endpoints. Only Gray-coded (single-bit-change) buses belong here.
module rsync_sync_stage #(
    parameter int unsigned WIDTH_P  = 4,
    parameter int unsigned STAGES_P = 2
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic [WIDTH_P-1:0] data_i,
    output logic [WIDTH_P-1:0] data_o
);

    logic [STAGES_P-1:0][WIDTH_P-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= data_i;
            for (int unsigned i = 1; i < STAGES_P; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign data_o = sync_q[STAGES_P-1];

endmodule

// File: rtl/gray_count_rx.sv
// Receive endpoint of the rsync event-count crossing: resynchronises a remote
// Gray count, accumulates its advance as pending credit, drains via pop.
module gray_count_rx
    import rsync_pkg::*;
#(
    parameter int unsigned WIDTH_P       = RSYNC_WIDTH,
    parameter int unsigned SYNC_STAGES_P = RSYNC_SYNC_STAGES,
    parameter int unsigned PEND_WIDTH_P  = WIDTH_P + 2
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [WIDTH_P-1:0]      gray_in,
    input  logic                    clr,
    input  logic                    pop_ready,
    output logic                    pop_valid,
    output logic [PEND_WIDTH_P-1:0] pending,
    output logic                    non_zero,
    output logic                    ovf
);

    localparam int unsigned SUM_W = PEND_WIDTH_P + 1;

    logic [WIDTH_P-1:0]      sync_g;
    logic [WIDTH_P-1:0]      bin;
    logic [WIDTH_P-1:0]      delta;
    logic [WIDTH_P-1:0]      base_q, base_d;
    logic [PEND_WIDTH_P-1:0] pending_q, pending_d;
    logic                    ovf_q, ovf_d;
    logic                    pop;
    logic [SUM_W-1:0]        sum;

    rsync_sync_stage #(
        .WIDTH_P  (WIDTH_P),
        .STAGES_P (SYNC_STAGES_P)
    ) u_sync (
        .clk     (clk),
        .reset_L (reset_L),
        .data_i  (gray_in),
        .data_o  (sync_g)
    );

    assign bin = WIDTH_P'(gray2bin(rsync_word_t'(sync_g), WIDTH_P));

    // Modular delta absorbs remote wrap; pop never underflows since it needs pending != 0.
    always_comb begin
        pop       = pop_valid & pop_ready;
        delta     = bin - base_q;
        sum       = {1'b0, pending_q} + SUM_W'(delta) - SUM_W'(pop);
        base_d    = bin;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        if (clr) begin
            pending_d = '0;
            ovf_d     = 1'b0;
        end else if (sum[SUM_W-1]) begin
            pending_d = '1;
            ovf_d     = 1'b1;
        end else begin
            pending_d = sum[PEND_WIDTH_P-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            base_q    <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            base_q    <= base_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pop_valid = |pending_q;
    assign non_zero  = pop_valid;
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_gray_count_rx.sv
// Self-checking bench for gray_count_rx: a cycle reference model pushes the
// expected outputs per edge into a scoreboard, popped and compared after it.
module tb_gray_count_rx;

    localparam int unsigned W    = 4;
    localparam int unsigned NS   = 2;
    localparam int unsigned PW   = 6;
    localparam int          PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [W-1:0]  gray_in;
    logic          clr;
    logic          pop_ready;
    logic          pop_valid;
    logic [PW-1:0] pending;
    logic          non_zero;
    logic          ovf;

    gray_count_rx #(
        .WIDTH_P       (W),
        .SYNC_STAGES_P (NS),
        .PEND_WIDTH_P  (PW)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .gray_in   (gray_in),
        .clr       (clr),
        .pop_ready (pop_ready),
        .pop_valid (pop_valid),
        .pending   (pending),
        .non_zero  (non_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pend;
        bit valid;
        bit ovf;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] sg_m[NS];
    logic [W-1:0] base_m;
    int           pend_m;
    bit           ovf_m;
    logic [W-1:0] cnt_r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Brute-force inverse of the Gray encoding.
    function automatic logic [W-1:0] g2b_m(input logic [W-1:0] g);
        logic [W-1:0] bb;
        for (int b = 0; b < (1 << W); b++) begin
            bb = W'(b);
            if ((bb ^ (bb >> 1)) == g) return bb;
        end
        return '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) sg_m[i] = '0;
        base_m = '0;
        pend_m = 0;
        ovf_m  = 1'b0;
    endtask

    task automatic model_edge();
        logic [W-1:0] bin;
        logic [W-1:0] dl;
        int           popm;
        int           s;
        exp_t         e;
        bin  = g2b_m(sg_m[NS-1]);
        dl   = bin - base_m;
        popm = (pend_m != 0 && pop_ready) ? 1 : 0;
        if (clr) begin
            pend_m = 0;
            ovf_m  = 1'b0;
        end else begin
            s = pend_m + int'(dl) - popm;
            if (s > PMAX) begin
                pend_m = PMAX;
                ovf_m  = 1'b1;
            end else begin
                pend_m = s;
            end
        end
        base_m = bin;
        for (int i = NS - 1; i > 0; i--) sg_m[i] = sg_m[i-1];
        sg_m[0] = gray_in;
        e.pend  = pend_m;
        e.valid = (pend_m != 0);
        e.ovf   = ovf_m;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        e = sb.pop_front();
        check("pending", 32'(pending), 32'(e.pend));
        check("pop_valid", 32'(pop_valid), 32'(e.valid));
        check("non_zero", 32'(non_zero), 32'(e.valid));
        check("ovf", 32'(ovf), 32'(e.ovf));
    endtask

    task automatic advance();
        cnt_r   = cnt_r + 1'b1;
        gray_in = cnt_r ^ (cnt_r >> 1);
    endtask

    task automatic settle();
        repeat (3) step();
    endtask

    initial begin
        reset_L   = 1'b0;
        gray_in   = '0;
        clr       = 1'b0;
        pop_ready = 1'b0;
        cnt_r     = '0;
        model_reset();
        #12;
        check("rst_pending", 32'(pending), 0);
        check("rst_valid", 32'(pop_valid), 0);
        check("rst_ovf", 32'(ovf), 0);
        @(negedge clk);
        reset_L = 1'b1;

        repeat (20) step();
        check("idle_pending", 32'(pending), 0);

        // first event: visible after the third edge following capture
        advance();
        step();
        step();
        check("lat_edge2", 32'(pending), 0);
        step();
        check("lat_edge3", 32'(pending), 1);
        repeat (4) begin advance(); step(); end
        settle();
        check("five_events", 32'(pending), 5);

        // rebaseline at remote count 12, then accumulate 3 events up to 15
        clr = 1'b1;
        while (cnt_r != 4'd12) begin advance(); step(); end
        settle();
        clr = 1'b0;
        step();
        check("clr_pending", 32'(pending), 0);
        repeat (3) begin advance(); step(); end
        settle();
        check("pre_wrap", 32'(pending), 3);
        advance();
        settle();
        check("wrap", 32'(pending), 4);

        // pop continuously; one new event lands on the edge pending is 2
        pop_ready = 1'b1;
        advance();
        step();
        check("pop_e1", 32'(pending), 3);
        step();
        check("pop_e2", 32'(pending), 2);
        step();
        check("pop_delta", 32'(pending), 2);
        step();
        check("pop_e4", 32'(pending), 1);
        step();
        check("pop_e5", 32'(pending), 0);
        check("pop_valid_drop", 32'(pop_valid), 0);
        step();
        pop_ready = 1'b0;

        repeat (70) begin advance(); step(); end
        settle();
        check("sat_pending", 32'(pending), PMAX);
        check("sat_ovf", 32'(ovf), 1);
        repeat (5) step();
        check("ovf_sticky", 32'(ovf), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_sat_pending", 32'(pending), 0);
        check("clr_sat_ovf", 32'(ovf), 0);
        advance();
        settle();
        check("post_clr_step", 32'(pending), 1);

        repeat (6) begin advance(); step(); end
        settle();
        check("pre_reset", 32'(pending), 7);

        // reset asserted between edges must clear outputs without waiting for a clock
        @(posedge clk);
        #3;
        reset_L = 1'b0;
        model_reset();
        sb.delete();
        #1;
        check("async_rst_pending", 32'(pending), 0);
        check("async_rst_valid", 32'(pop_valid), 0);
        check("async_rst_nz", 32'(non_zero), 0);
        check("async_rst_ovf", 32'(ovf), 0);
        cnt_r   = '0;
        gray_in = '0;
        #3;
        reset_L = 1'b1;
        settle();
        check("post_rst_idle", 32'(pending), 0);
        repeat (3) begin advance(); step(); end
        settle();
        check("post_rst_count", 32'(pending), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
